// File: rtl/sdram_pkg.sv
// Constants and FSM encoding shared by the SDRAM-side blocks on the 143 MHz domain.
// The framebuffer is 320x240 RGB565 pixels.
package sdram_pkg;

  localparam int FRAME_PIXELS = 76800;
  localparam int ADDR_W       = 20;
  localparam int DATA_W       = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } prefetch_state_t;

endpackage

// File: rtl/pix_fifo.sv
// Synchronous show-ahead FIFO: dout presents the head entry without a pop.
// A flush wins over a push or pop in the same cycle.
module pix_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int              PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_LEVEL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level == '0);
  assign do_push = push && (level != FULL_LEVEL);
  assign do_pop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and level alone define validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/vga_read_prefetch.sv
// Linear framebuffer read prefetcher: one outstanding level-held SDRAM read at a time,
// results buffered in a show-ahead FIFO popped by the VGA scan-out.
module vga_read_prefetch #(
  parameter int FRAME_PIXELS = sdram_pkg::FRAME_PIXELS,
  parameter int ADDR_W       = sdram_pkg::ADDR_W,
  parameter int DATA_W       = sdram_pkg::DATA_W,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk_143MHz,
  input  logic                          rst_n,
  input  logic                          frame_start,
  input  logic                          pix_req,
  output logic [DATA_W-1:0]             pix_data,
  output logic                          pix_valid,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          write_busy,
  output logic                          start_read,
  output logic [ADDR_W-1:0]             read_addr,
  input  logic [DATA_W-1:0]             read_pixel,
  input  logic                          read_valid
);

  import sdram_pkg::*;

  localparam int                LVL_W      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0]  FULL_LEVEL = LVL_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FRAME_PIXELS - 1);

  prefetch_state_t   state;
  prefetch_state_t   state_d;
  logic [ADDR_W-1:0] next_addr;
  logic              issue;
  logic              accept;
  logic              fifo_empty;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state;
    issue   = 1'b0;
    accept  = 1'b0;
    case (state)
      IDLE: begin
        if (!frame_start && !write_busy && fifo_level != FULL_LEVEL) begin
          state_d = REQ;
          issue   = 1'b1;
        end
      end
      REQ: begin
        // A completion coinciding with frame_start belongs to the old frame and is dropped.
        if (read_valid) begin
          state_d = IDLE;
          accept  = !frame_start;
        end else if (frame_start) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (read_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_143MHz or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      start_read <= 1'b0;
      read_addr  <= '0;
      next_addr  <= '0;
      underflow  <= 1'b0;
    end else begin
      state      <= state_d;
      start_read <= (state_d != IDLE);
      if (issue) read_addr <= next_addr;

      if (frame_start)  next_addr <= '0;
      else if (accept)  next_addr <= (next_addr == LAST_ADDR) ? '0 : next_addr + 1'b1;

      if (frame_start)                underflow <= 1'b0;
      else if (pix_req && fifo_empty) underflow <= 1'b1;
    end
  end

  pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk_143MHz),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (pix_req),
    .flush (frame_start),
    .din   (read_pixel),
    .dout  (pix_data),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign pix_valid = !fifo_empty;

endmodule
